// File: rtl/register_file_param_pkg.sv
// Shared defaults and types for the parametrised register file.
// Imported by the interface, the storage cell and the top.
package register_file_param_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_ADDR_W = 5;

    localparam logic [DEFAULT_WIDTH-1:0] ZERO_WORD = '0;

    typedef logic [DEFAULT_ADDR_W-1:0] addr_t;
    typedef logic [DEFAULT_WIDTH-1:0]  data_t;

    // True when address a selects a physically present entry.
    function automatic bit addr_in_range(input int unsigned a,
                                         input int unsigned depth);
        return a < depth;
    endfunction

endpackage

// File: rtl/register_file_param_if.sv
// Write port plus two read ports of the register file.
// The master drives addresses and write data; the slave returns read data.
interface register_file_param_if
    import register_file_param_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
);

    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;

    modport master (
        output we,
        output wa,
        output wd,
        output ra1,
        output ra2,
        input  rd1,
        input  rd2
    );

    modport slave (
        input  we,
        input  wa,
        input  wd,
        input  ra1,
        input  ra2,
        output rd1,
        output rd2
    );

endinterface

// File: rtl/register_file_param_cell.sv
// One WIDTH-bit storage word with synchronous active-high clear
// and load enable.
module register_cell
    import register_file_param_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/register_file_param.sv
// DEPTH x WIDTH register file: one synchronous write port, two
// combinational read ports, optional hardwired zero entry and bypass.
module register_file_param
    import register_file_param_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    register_file_param_if.slave   rf
);

    logic [WIDTH-1:0] entry [DEPTH];
    logic [DEPTH-1:0] wen;
    logic             byp_en;

    // Out-of-range addresses match no index, so they never alias.
    always_comb begin
        wen = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wen[i] = rf.we && (rf.wa == ADDR_W'(i));
        end
        if (ZERO_REG != 0) begin
            wen[0] = 1'b0;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (ZERO_REG != 0 && i == 0) begin : g_zero
            assign entry[i] = '0;
        end else begin : g_cell
            register_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk   (clk),
                .reset (reset),
                .en_i  (wen[i]),
                .d_i   (rf.wd),
                .q_o   (entry[i])
            );
        end
    end

    assign byp_en = (BYPASS != 0) && rf.we && !reset;

    // Range and zero-entry checks come first so a write-ignored
    // address can never forward wd.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [ADDR_W-1:0] wa,
        input logic [WIDTH-1:0]  wd,
        input logic              byp,
        input logic [WIDTH-1:0]  ent [DEPTH]
    );
        logic [WIDTH-1:0] v;
        v = '0;
        if (!addr_in_range(32'(ra), 32'(DEPTH))) begin
            v = '0;
        end else if (ZERO_REG != 0 && ra == '0) begin
            v = '0;
        end else if (byp && ra == wa) begin
            v = wd;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ra == ADDR_W'(i)) begin
                    v = ent[i];
                end
            end
        end
        return v;
    endfunction

    always_comb begin
        rf.rd1 = read_port(rf.ra1, rf.wa, rf.wd, byp_en, entry);
        rf.rd2 = read_port(rf.ra2, rf.wa, rf.wd, byp_en, entry);
    end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench: three register file variants driven in lockstep.
module tb_register_file_param;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    register_file_param_if #(.WIDTH(32), .ADDR_W(5)) if0 ();
    register_file_param_if #(.WIDTH(32), .ADDR_W(5)) if1 ();
    register_file_param_if #(.WIDTH(32), .ADDR_W(5)) if2 ();

    // d0: no bypass, d1: bypass, d2: 20 entries with bypass
    register_file_param #(
        .WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)
    ) u_d0 (
        .clk   (clk),
        .reset (reset),
        .rf    (if0)
    );

    register_file_param #(
        .WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
    ) u_d1 (
        .clk   (clk),
        .reset (reset),
        .rf    (if1)
    );

    register_file_param #(
        .WIDTH(32), .DEPTH(20), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
    ) u_d2 (
        .clk   (clk),
        .reset (reset),
        .rf    (if2)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic wr(input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
        if0.we = we; if0.wa = wa; if0.wd = wd;
        if1.we = we; if1.wa = wa; if1.wd = wd;
        if2.we = we; if2.wa = wa; if2.wd = wd;
    endtask

    task automatic rd(input logic [4:0] ra1, input logic [4:0] ra2);
        if0.ra1 = ra1; if0.ra2 = ra2;
        if1.ra1 = ra1; if1.ra2 = ra2;
        if2.ra1 = ra1; if2.ra2 = ra2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        wr(1'b0, 5'd0, 32'd0);
        rd(5'd0, 5'd0);

        edge1();
        reset = 1'b0;
        rd(5'd5, 5'd31);
        #1;
        chk("rst_rd1", if0.rd1, 32'd0);
        chk("rst_rd2", if0.rd2, 32'd0);

        @(negedge clk);
        wr(1'b1, 5'd7, 32'd52);
        rd(5'd7, 5'd7);
        #1;
        chk("pre_edge_nobyp", if0.rd1, 32'd0);
        chk("pre_edge_byp", if1.rd1, 32'd52);
        edge1();
        wr(1'b0, 5'd7, 32'd52);
        #1;
        chk("post_edge", if0.rd1, 32'd52);
        #2;
        chk("quarter_later", if0.rd1, 32'd52);

        @(negedge clk);
        wr(1'b1, 5'd0, 32'hDEADBEEF);
        rd(5'd0, 5'd0);
        #1;
        chk("zero_byp", if1.rd1, 32'd0);
        edge1();
        wr(1'b0, 5'd0, 32'd0);
        #1;
        chk("zero_nobyp", if0.rd1, 32'd0);
        chk("zero_byp_after", if1.rd1, 32'd0);

        @(negedge clk);
        wr(1'b1, 5'd3, 32'h1234);
        rd(5'd0, 5'd3);
        #1;
        chk("byp_rd2", if1.rd2, 32'h1234);
        chk("nobyp_rd2", if0.rd2, 32'd0);
        edge1();
        wr(1'b0, 5'd3, 32'd0);
        #1;
        chk("stored_rd2", if0.rd2, 32'h1234);

        @(negedge clk);
        wr(1'b1, 5'd5, 32'd55);
        edge1();
        @(negedge clk);
        wr(1'b1, 5'd25, 32'd99);
        rd(5'd25, 5'd5);
        #1;
        chk("oor_byp_rd1", if2.rd1, 32'd0);
        chk("oor_rd2_pre", if2.rd2, 32'd55);
        edge1();
        wr(1'b0, 5'd0, 32'd0);
        #1;
        chk("oor_rd1", if2.rd1, 32'd0);
        chk("oor_rd2_alias", if2.rd2, 32'd55);
        chk("inrange_25", if0.rd1, 32'd99);
        rd(5'd9, 5'd25);
        #1;
        chk("oor_rd1_9", if2.rd1, 32'd0);
        chk("oor_rd2_25", if2.rd2, 32'd0);

        @(negedge clk);
        wr(1'b1, 5'd4, 32'd10);
        edge1();
        @(negedge clk);
        wr(1'b1, 5'd9, 32'd20);
        edge1();
        @(negedge clk);
        wr(1'b0, 5'd0, 32'd0);
        rd(5'd4, 5'd9);
        #1;
        chk("pre_rst_4", if0.rd1, 32'd10);
        chk("pre_rst_9", if0.rd2, 32'd20);
        @(negedge clk);
        reset = 1'b1;
        wr(1'b1, 5'd4, 32'd77);
        #1;
        chk("rst_blocks_byp", if1.rd1, 32'd10);
        edge1();
        reset = 1'b0;
        wr(1'b0, 5'd0, 32'd0);
        #1;
        chk("rst_prio_4", if0.rd1, 32'd0);
        chk("rst_prio_9", if0.rd2, 32'd0);
        chk("rst_prio_byp4", if1.rd1, 32'd0);
        @(negedge clk);
        wr(1'b1, 5'd4, 32'd77);
        edge1();
        wr(1'b0, 5'd0, 32'd0);
        #1;
        chk("post_rst_wr", if0.rd1, 32'd77);

        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wr(1'b1, 5'(i), 32'(i * 3));
        end
        edge1();
        wr(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            #1;
            chk($sformatf("sweep_rd1_%0d", i), if0.rd1, 32'(i * 3));
            chk($sformatf("sweep_rd2_%0d", i), if0.rd2,
                32'((31 - i) * 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised multi-entry register file, successor to the single 32-bit register.
- Bank of DEPTH registers, each WIDTH bits, with one synchronous write port and two combinational read ports.
- Sits in the datapath as the CPU general-purpose register file, e.g. MIPS $0-$31.
- Adds what the single register lacks: write enable, addressing, hardwired zero register, optional write-to-read bypass, and defined handling of out-of-range addresses.

Parameters:
- WIDTH, 32: bits per register.
- DEPTH, 32: number of registers; legal range 2..256, need not be a power of two.
- ADDR_W, 5: address width; must satisfy 2^ADDR_W >= DEPTH.
- ZERO_REG, 1: 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = a read of the address being written this cycle returns wd (write-first view); 0 = returns the stored value.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears all entries on the rising edge.
- we  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  WIDTH  write data.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high, sampled only at the rising edge of clk.
- Reset:
  - reset=1 at a rising edge sets all DEPTH entries to 0.
  - reset has priority over a simultaneous we=1; the write is dropped.
  - Between power-up and the first reset edge, contents are undefined (X in simulation).
  - After the reset edge, rd1 and rd2 read 0 for every address.
- Write:
  - At a rising edge with reset=0, we=1 and wa<DEPTH, entry[wa] <= wd.
  - Write latency is 1 edge. A stored value is visible through the non-bypass path after that edge.
  - we=0: no entry changes.
  - wa>=DEPTH: write ignored, no wrap-around or aliasing.
  - ZERO_REG=1 and wa=0: write ignored.
- Read:
  - Combinational, zero latency: rd1 follows ra1 and rd2 follows ra2 within the same cycle.
  - Priority, first match wins:
    1. ra>=DEPTH -> 0.
    2. ZERO_REG=1 and ra=0 -> 0.
    3. BYPASS=1, we=1, reset=0 and ra==wa -> wd.
    4. Otherwise -> entry[ra].
  - Both ports are independent and may read the same address.
  - The bypass result for an address that is write-ignored (out of range or zero register) is taken from rules 1 and 2, never wd.
- State between edges: entries never change except at a rising edge of clk. Glitches on we, wa or wd between edges have no effect on stored state.
- Widths: no arithmetic; data is passed through unmodified. Addresses compare as unsigned.
- Reset mid-sequence: a reset edge between two writes discards all prior writes. The next write after reset behaves normally.

Decomposition:
- Shared package (memory defaults):
  - DEFAULT_WIDTH=32, DEFAULT_DEPTH=32, DEFAULT_ADDR_W=5.
  - A zero-word constant.
  - Address and data typedefs parametrised by width.
- Sub-module register_cell: one WIDTH-bit register with synchronous active-high reset and write enable (clk, reset, en, D, Q).
  - Instantiated DEPTH times via generate.
  - Entry 0 is omitted when ZERO_REG=1.
- The write decoder and read muxes stay in register_file_param.

Test Plan:
- Reset: set reset=1 and wait one rising edge, then reset=0. Expect rd1=rd2=0 for ra1=5, ra2=31.
- Write/read with timing: we=1, wa=7, wd=52.
  - Before the edge, with BYPASS=0, rd1(ra1=7)=0.
  - After the edge, with we=0, rd1=52.
  - A quarter period later, rd1 is still 52.
- Zero register and bypass: with ZERO_REG=1, write wd=0xDEADBEEF to wa=0, then read ra1=0 -> 0.
  - With BYPASS=1, we=1, wa=3, wd=0x1234 and ra2=3, expect rd2=0x1234 in the same cycle before the edge.
  - Also check ra1=0 still reads 0 when wa=0 is being written with BYPASS=1.
- Out of range: instantiate DEPTH=20, ADDR_W=5.
  - Write wd=99 to wa=25 -> no entry changes; rd1(ra1=25)=0.
  - rd2(ra2=5) is unchanged from its prior value.
- Reset priority and mid-sequence reset:
  - Write 10 to entry 4 and 20 to entry 9.
  - Assert reset=1 with we=1, wa=4, wd=77 at the same edge.
  - Expect entry 4=0 and entry 9=0 afterwards.
  - Then a normal write of 77 to wa=4 reads back 77.
- Dual-port independence: fill entries 1..31 with value i*3. Sweep ra1=i and ra2=31-i; expect rd1=3i and rd2=3(31-i) for every i.
